// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8- or 32-bit frames. The processor side mirrors the SPI master.
// SCLK/MOSI/SS are resynchronised to clk and edge-detected; every output is registered.
module spi_slave #(
  parameter int          SYNC = 2,
  parameter logic [31:0] FILL = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast,
  input  logic        start,
  input  logic [31:0] dataTx,
  output logic        txrdy,
  output logic [31:0] dataRx,
  input  logic        done,
  output logic        rdy,
  output logic        ovr,
  output logic        active,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS,
  output logic        MISO,
  output logic        MISOen,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_e;

  logic [SYNC-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic            sclk_hist_q, ss_hist_q;
  logic            sclk_s, mosi_s, ss_s;
  logic            sclk_rise, sclk_fall, ss_fall;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        len_q, len_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] data_rx_q, data_rx_d;
  logic        txrdy_q, txrdy_d;
  logic        rdy_q, rdy_d;
  logic        ovr_q, ovr_d;
  logic        active_q, active_d;
  logic        misoen_q, misoen_d;
  logic        miso_q, miso_d;

  assign sclk_s    = sclk_sync_q[SYNC-1];
  assign mosi_s    = mosi_sync_q[SYNC-1];
  assign ss_s      = ss_sync_q[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC-2:0], SS};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    hold_d    = hold_q;
    data_rx_d = data_rx_q;
    txrdy_d   = txrdy_q;
    rdy_d     = rdy_q;
    ovr_d     = ovr_q;
    miso_d    = miso_q;
    active_d  = ~ss_s;
    misoen_d  = ~ss_s;

    if (done) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: if (ss_fall) state_d = LOAD;
      LOAD: begin
        len_d = fast;
        cnt_d = 6'd0;
        if (!txrdy_q) begin
          tx_d    = fast ? hold_q : {hold_q[7:0], FILL[23:0]};
          txrdy_d = 1'b1;
        end else begin
          tx_d = FILL;
        end
        miso_d  = tx_d[31];
        state_d = ss_s ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (ss_s) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[30:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == (len_q ? 6'd32 : 6'd8)) begin
            data_rx_d = len_q ? rx_d : {24'b0, rx_d[7:0]};
            rdy_d     = 1'b1;
            ovr_d     = ovr_q | (rdy_q & ~done);
            state_d   = LOAD;
          end
        // With cnt at zero the falling edge closes the previous frame and must not consume the new MSB.
        end else if (sclk_fall && cnt_q != 6'd0) begin
          tx_d   = {tx_q[30:0], 1'b1};
          miso_d = tx_q[30];
        end
      end
      default: state_d = IDLE;
    endcase

    // A write in the LOAD cycle stays pending; LOAD above used the old holding word.
    if (start) begin
      hold_d  = dataTx;
      txrdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      len_q     <= 1'b0;
      tx_q      <= FILL;
      rx_q      <= '0;
      hold_q    <= FILL;
      data_rx_q <= '0;
      txrdy_q   <= 1'b1;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
      active_q  <= 1'b0;
      misoen_q  <= 1'b0;
      miso_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      hold_q    <= hold_d;
      data_rx_q <= data_rx_d;
      txrdy_q   <= txrdy_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
      active_q  <= active_d;
      misoen_q  <= misoen_d;
      miso_q    <= miso_d;
    end
  end

  assign txrdy     = txrdy_q;
  assign dataRx    = data_rx_q;
  assign rdy       = rdy_q;
  assign ovr       = ovr_q;
  assign active    = active_q;
  assign MISO      = miso_q;
  assign MISOen    = misoen_q;
  assign dbg_state = state_q;

endmodule
